regfile_wb_arbiter: RTL

Write-port controller for the 32x32 integer register bank. It shares the bank's single write port between two writeback requesters: A (ALU/CSR results) and B (load/memory results). Each requester has a 2-entry FIFO, and a round-robin grant feeds a registered write stage. A 32-bit busy scoreboard exposes pending writes to the issue logic for hazard stalls. The bank has no write enable and writes on every edge, so this block parks the write port on x0 whenever there is no real write.

---
 rtl/regfile_wb_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Two-entry in-order FIFO; exposes each slot's key field and valid bit for scoreboarding.
// Latency: a push becomes the head after the capturing edge (no bypass); pop frees the head at the edge.
// Backpressure: owner pushes only while count < 2 and pops only while count > 0.
module wb_fifo2 #(
  parameter int W  = 8,
  parameter int KW = 1
) (
  input  logic                rd_clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [W-1:0]        push_dat,
  input  logic                pop,
  output logic [W-1:0]        head_dat,
  output logic [1:0]          count,
  output logic [1:0][KW-1:0]  ent_key,
  output logic [1:0]          ent_vld
);

  logic [1:0][W-1:0] mem;
  logic              head;
  logic              tail;

  // Storage, pointers and occupancy; pointers wrap 1->0 by toggling.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      mem   <= '0;
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[tail] <= push_dat;
        tail      <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_dat   = mem[head];
  assign ent_key[0] = mem[0][W-1 -: KW];
  assign ent_key[1] = mem[1][W-1 -: KW];
  // A slot holds live data when the FIFO is full, or when it is the head of a single entry.
  assign ent_vld[0] = (count == 2'd2) || ((count == 2'd1) && (head == 1'b0));
  assign ent_vld[1] = (count == 2'd2) || ((count == 2'd1) && (head == 1'b1));

endmodule

// Shares the register bank write port between requesters A and B via per-requester FIFOs and round-robin.
// Latency: accept at edge N, on wr_rd/wr_val after edge N+1, captured by the bank at edge N+2.
// Backpressure: x_ready drops while that FIFO holds 2 entries; the write stage never stalls.
module regfile_wb_arbiter (
  input  logic        rd_clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_val,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_val,
  output logic        b_ready,
  output logic [4:0]  wr_rd,
  output logic [31:0] wr_val,
  output logic [31:0] busy,
  output logic        idle
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
  } wb_req_t;

  typedef enum logic {GNT_A = 1'b0, GNT_B = 1'b1} gnt_e;

  wb_req_t         a_req, b_req, a_head, b_head, wr_q;
  logic [1:0]      a_cnt, b_cnt;
  logic [1:0][4:0] a_key, b_key;
  logic [1:0]      a_ev, b_ev;
  logic            a_push, b_push, a_pop, b_pop;
  logic            grant_vld;
  gnt_e            grant_sel, last_grant;

  assign a_req = '{rd: a_rd, val: a_val};
  assign b_req = '{rd: b_rd, val: b_val};

  // Ready comes from the registered count, so a full FIFO never accepts in the cycle it pops.
  assign a_ready = rst_n && (a_cnt != 2'd2);
  assign b_ready = rst_n && (b_cnt != 2'd2);

  // Writes to x0 complete the handshake but are dropped here.
  assign a_push = a_valid && a_ready && (a_rd != 5'd0);
  assign b_push = b_valid && b_ready && (b_rd != 5'd0);

  wb_fifo2 #(.W($bits(wb_req_t)), .KW(5)) u_fifo_a (
    .rd_clk   (rd_clk),
    .rst_n    (rst_n),
    .push     (a_push),
    .push_dat (a_req),
    .pop      (a_pop),
    .head_dat (a_head),
    .count    (a_cnt),
    .ent_key  (a_key),
    .ent_vld  (a_ev)
  );

  wb_fifo2 #(.W($bits(wb_req_t)), .KW(5)) u_fifo_b (
    .rd_clk   (rd_clk),
    .rst_n    (rst_n),
    .push     (b_push),
    .push_dat (b_req),
    .pop      (b_pop),
    .head_dat (b_head),
    .count    (b_cnt),
    .ent_key  (b_key),
    .ent_vld  (b_ev)
  );

  // Round-robin on the FIFO heads: under contention the side not granted last time wins.
  always_comb begin
    grant_vld = (a_cnt != 2'd0) || (b_cnt != 2'd0);
    grant_sel = GNT_A;
    if ((a_cnt != 2'd0) && (b_cnt != 2'd0)) begin
      grant_sel = (last_grant == GNT_B) ? GNT_A : GNT_B;
    end else if (b_cnt != 2'd0) begin
      grant_sel = GNT_B;
    end
  end

  assign a_pop = grant_vld && (grant_sel == GNT_A);
  assign b_pop = grant_vld && (grant_sel == GNT_B);

  // Write stage: load the granted head, otherwise park the bank on x0.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q       <= '0;
      last_grant <= GNT_B;
    end else if (grant_vld) begin
      wr_q       <= (grant_sel == GNT_A) ? a_head : b_head;
      last_grant <= grant_sel;
    end else begin
      wr_q       <= '0;
    end
  end

  assign wr_rd  = wr_q.rd;
  assign wr_val = wr_q.val;

  // Pending-write scoreboard over live FIFO slots and the write stage; x0 is never busy.
  always_comb begin
    busy = '0;
    if (a_ev[0]) busy[a_key[0]] = 1'b1;
    if (a_ev[1]) busy[a_key[1]] = 1'b1;
    if (b_ev[0]) busy[b_key[0]] = 1'b1;
    if (b_ev[1]) busy[b_key[1]] = 1'b1;
    busy[wr_q.rd] = 1'b1;
    busy[0]       = 1'b0;
  end

  assign idle = (a_cnt == 2'd0) && (b_cnt == 2'd0) && (wr_q.rd == 5'd0);

endmodule
